// File: rtl/benes_xbar_pipe.sv
// Pipelined Benes lane crossbar: STAGES registered 2x2-switch layers driven by one held ctrl vector.
// Latency STAGES cycles; valid/ready with collapsing bubbles; reconfiguration waits for the pipe to drain.
module benes_xbar_pipe #(
  parameter int SIZE = 32,
  parameter int DW = 16,
  localparam int TAGWIDTH = $clog2(SIZE),
  localparam int STAGES = 2 * TAGWIDTH - 1,
  localparam int BITWIDTH = STAGES * (SIZE / 2),
  localparam int OCCW = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [BITWIDTH-1:0] cfg_ctrl,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data [SIZE-1:0],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data [SIZE-1:0],
  output logic                cfg_loaded,
  output logic [OCCW-1:0]     occupancy
);

  typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] ctrl_q, ctrl_d;
  logic                cfg_loaded_q, cfg_loaded_d;
  logic [OCCW-1:0]     occupancy_q, occupancy_d;
  logic [STAGES-1:0]   vld_q, vld_d;
  logic [STAGES-1:0]   load_en;
  logic                full_tail;
  logic                in_fire, out_fire;
  int                  stride, pos;

  logic [DW-1:0] data_q [STAGES-1:0][SIZE-1:0];
  logic [DW-1:0] data_d [STAGES-1:0][SIZE-1:0];
  logic [DW-1:0] lin    [STAGES-1:0][SIZE-1:0];
  logic [DW-1:0] lout   [STAGES-1:0][SIZE-1:0];

  // Layer i pairs lanes pos and pos+stride; strides double toward the middle layer then halve again.
  always_comb begin
    stride = 1;
    pos = 0;
    lin[0] = in_data;
    for (int i = 1; i < STAGES; i++) lin[i] = data_q[i-1];
    for (int i = 0; i < STAGES; i++) begin
      lout[i] = lin[i];
      stride = 1 << ((i < STAGES - 1 - i) ? i : (STAGES - 1 - i));
      for (int j = 0; j < SIZE / 2; j++) begin
        pos = (j % stride) + 2 * stride * (j / stride);
        if (ctrl_q[i*(SIZE/2)+j]) begin
          lout[i][pos]        = lin[i][pos+stride];
          lout[i][pos+stride] = lin[i][pos];
        end
      end
    end
  end

  // A stage may load unless it and every stage after it are full and the output is stalled.
  always_comb begin
    full_tail = !out_ready;
    load_en   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_tail  = full_tail && vld_q[k];
      load_en[k] = !full_tail;
    end
  end

  assign in_ready  = (state_q == RUN) && !cfg_valid && load_en[0];
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_q[STAGES-1];
  assign out_fire  = out_valid && out_ready;
  assign out_data  = data_q[STAGES-1];
  assign cfg_loaded = cfg_loaded_q;
  assign occupancy  = occupancy_q;

  always_comb begin
    vld_d = vld_q;
    if (load_en[0]) vld_d[0] = in_fire;
    for (int k = 1; k < STAGES; k++) begin
      if (load_en[k]) vld_d[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = load_en[k] ? lout[k] : data_q[k];
    end
  end

  always_comb begin
    occupancy_d = occupancy_q;
    if (in_fire && !out_fire) occupancy_d = occupancy_q + OCCW'(1);
    else if (out_fire && !in_fire) occupancy_d = occupancy_q - OCCW'(1);
  end

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    cfg_loaded_d = cfg_loaded_q;
    cfg_ready    = 1'b0;
    case (state_q)
      UNCFG: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          ctrl_d       = cfg_ctrl;
          cfg_loaded_d = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (cfg_valid) state_d = DRAIN;
      end
      DRAIN: begin
        cfg_ready = (occupancy_q == '0);
        if (cfg_valid && cfg_ready) begin
          ctrl_d  = cfg_ctrl;
          state_d = RUN;
        end else if (!cfg_valid) begin
          state_d = RUN;
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= UNCFG;
      ctrl_q       <= '0;
      cfg_loaded_q <= 1'b0;
      occupancy_q  <= '0;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      cfg_loaded_q <= cfg_loaded_d;
      occupancy_q  <= occupancy_d;
      vld_q        <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_benes_xbar_pipe.sv
// Randomized and directed bench for benes_xbar_pipe with a lane-array reference and output scoreboard.
module tb_benes_xbar_pipe;
  localparam int SIZE = 32;
  localparam int DW = 16;
  localparam int STAGES = 9;
  localparam int BITWIDTH = STAGES * (SIZE / 2);
  localparam int OCCW = 4;
  localparam int VW = SIZE * DW;

  typedef logic [VW-1:0] vec_t;
  typedef logic [BITWIDTH-1:0] cfg_t;

  logic                clk = 1'b0;
  logic                n_rst = 1'b0;
  logic                cfg_valid, cfg_ready;
  logic [BITWIDTH-1:0] cfg_ctrl;
  logic                in_valid, in_ready;
  logic [DW-1:0]       in_data [SIZE-1:0];
  logic                out_valid, out_ready;
  logic [DW-1:0]       out_data [SIZE-1:0];
  logic                cfg_loaded;
  logic [OCCW-1:0]     occupancy;

  benes_xbar_pipe #(.SIZE(SIZE), .DW(DW)) dut (
    .clk(clk), .n_rst(n_rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ctrl(cfg_ctrl),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_loaded(cfg_loaded), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   cfg_seen, in_seen;
  cfg_t cur_cfg = '0;
  vec_t last_out, last_in;
  vec_t exp_q [$];

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t pack_lanes(input logic [DW-1:0] a [SIZE-1:0]);
    vec_t r;
    for (int k = 0; k < SIZE; k++) r[k*DW +: DW] = a[k];
    return r;
  endfunction

  function automatic vec_t lane_of(input vec_t v, input int src_of_lane [SIZE]);
    vec_t r;
    for (int k = 0; k < SIZE; k++) r[k*DW +: DW] = v[src_of_lane[k]*DW +: DW];
    return r;
  endfunction

  // Reference: walk the lane array through each layer, swapping the pairs the ctrl bits select.
  function automatic vec_t ref_perm(input vec_t v, input cfg_t c);
    logic [DW-1:0] l [SIZE];
    logic [DW-1:0] t;
    int s, p;
    for (int k = 0; k < SIZE; k++) l[k] = v[k*DW +: DW];
    for (int i = 0; i < STAGES; i++) begin
      s = 1 << ((i < STAGES - 1 - i) ? i : STAGES - 1 - i);
      for (int j = 0; j < SIZE / 2; j++) begin
        p = (j % s) + 2 * s * (j / s);
        if (c[i*(SIZE/2)+j]) begin
          t = l[p]; l[p] = l[p+s]; l[p+s] = t;
        end
      end
    end
    for (int k = 0; k < SIZE; k++) ref_perm[k*DW +: DW] = l[k];
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    for (int b = 0; b < BITWIDTH; b++) c[b] = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < SIZE; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    for (int k = 0; k < SIZE; k++) in_data[k] = v[k*DW +: DW];
  endtask

  // One clock: handshakes are judged at the falling edge, then state is compared just after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (cfg_valid && cfg_ready) begin
      cur_cfg = cfg_ctrl;
      cfg_seen = 1;
    end
    if (out_valid && out_ready) begin
      n_out++;
      last_out = pack_lanes(out_data);
      if (exp_q.size() == 0) chk("spurious_out", VW'(1), VW'(0));
      else chk("out_data", last_out, exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      in_seen = 1;
      last_in = pack_lanes(in_data);
      exp_q.push_back(ref_perm(last_in, cur_cfg));
    end
    @(posedge clk);
    #1;
    chk("occupancy", VW'(occupancy), VW'(exp_q.size()));
  endtask

  task automatic load_cfg(input cfg_t c);
    int n = 0;
    cfg_valid = 1; cfg_ctrl = c; cfg_seen = 0;
    while (!cfg_seen && n < 60) begin step(); n++; end
    cfg_valid = 0;
    chk("cfg_handshake", VW'(cfg_seen), VW'(1));
  endtask

  task automatic one_vec(input string tag, input cfg_t c, input vec_t v, input vec_t exp);
    int n = 0;
    int base;
    load_cfg(c);
    drive_vec(v); in_valid = 1; in_seen = 0;
    while (!in_seen && n < 40) begin step(); n++; end
    in_valid = 0;
    base = n_out; n = 0;
    while (n_out == base && n < 40) begin step(); n++; end
    chk({tag, "_cnt"}, VW'(n_out - base), VW'(1));
    chk(tag, last_out, exp);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1; in_valid = 0; cfg_valid = 0;
    while (exp_q.size() != 0 && n < 300) begin step(); n++; end
    chk("drained", VW'(exp_q.size()), VW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t ident, v0, v;
    cfg_t c;
    int   map [SIZE];
    int   lat, n, base, sent, first_c, last_c;
    bit   held;
    vec_t held_dat;

    cfg_valid = 0; cfg_ctrl = '0; in_valid = 0; out_ready = 1;
    for (int k = 0; k < SIZE; k++) begin
      in_data[k] = '0;
      ident[k*DW +: DW] = DW'(k);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_cfg_loaded", VW'(cfg_loaded), VW'(0));
    chk("rst_occupancy", VW'(occupancy), VW'(0));
    chk("rst_in_ready", VW'(in_ready), VW'(0));
    chk("rst_cfg_ready", VW'(cfg_ready), VW'(1));
    n_rst = 1;

    // Identity configuration and first-beat latency.
    load_cfg('0);
    chk("cfg_loaded", VW'(cfg_loaded), VW'(1));
    drive_vec(ident); in_valid = 1; in_seen = 0;
    step();
    chk("first_hs", VW'(in_seen), VW'(1));
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin step(); lat++; end
    chk("latency", VW'(lat), VW'(STAGES));
    chk("ident_data", pack_lanes(out_data), ident);
    step();

    // Single switch in layer 0 and in layer 7.
    for (int k = 0; k < SIZE; k++) map[k] = k;
    map[0] = 1; map[1] = 0;
    c = '0; c[0] = 1'b1;
    one_vec("l0_sw0", c, ident, lane_of(ident, map));
    for (int k = 0; k < SIZE; k++) map[k] = k;
    map[0] = 2; map[2] = 0;
    c = '0; c[7*(SIZE/2)] = 1'b1;
    one_vec("l7_sw0", c, ident, lane_of(ident, map));

    // Middle layer fully crossed rotates lanes by 16; stream 20 back-to-back.
    for (int k = 0; k < SIZE; k++) map[k] = (k + 16) % SIZE;
    c = '0; c[4*(SIZE/2) +: SIZE/2] = '1;
    load_cfg(c);
    base = n_out; sent = 0; n = 0; first_c = 0; last_c = 0;
    v0 = rand_vec(); v = v0; drive_vec(v);
    while ((n_out - base) < 20 && n < 100) begin
      in_valid = (sent < 20);
      in_seen = 0;
      step();
      if (in_seen) begin sent++; v = rand_vec(); drive_vec(v); end
      if ((n_out - base) == 1 && first_c == 0) begin
        first_c = cyc;
        chk("rot16", last_out, lane_of(v0, map));
      end
      if ((n_out - base) == 20 && last_c == 0) last_c = cyc;
      n++;
    end
    in_valid = 0;
    chk("b2b_count", VW'(n_out - base), VW'(20));
    chk("b2b_span", VW'(last_c - first_c), VW'(19));

    // Backpressure: 15 stalled cycles in a 12-vector stream.
    load_cfg(rand_cfg());
    base = n_out; sent = 0; held = 0; held_dat = '0;
    drive_vec(rand_vec());
    for (int t = 0; t < 200 && (sent < 12 || exp_q.size() != 0); t++) begin
      out_ready = !(t >= 3 && t < 18);
      if (t >= 3 && t < 18 && out_valid) begin
        if (held) chk("held_data", pack_lanes(out_data), held_dat);
        held = 1; held_dat = pack_lanes(out_data);
      end
      if (t == 17) begin
        chk("bp_in_ready", VW'(in_ready), VW'(0));
        chk("bp_occ_full", VW'(occupancy), VW'(STAGES));
        chk("bp_out_valid", VW'(out_valid), VW'(1));
      end
      in_valid = (sent < 12);
      in_seen = 0;
      step();
      if (in_seen) begin sent++; drive_vec(rand_vec()); end
    end
    out_ready = 1; in_valid = 0;
    chk("bp_count", VW'(n_out - base), VW'(12));

    // Reconfiguration with 5 vectors in flight: old ones keep the old permutation.
    sent = 0; n = 0;
    drive_vec(rand_vec());
    while (sent < 5 && n < 40) begin
      in_valid = 1; in_seen = 0;
      step();
      if (in_seen) begin sent++; drive_vec(rand_vec()); end
      n++;
    end
    v = rand_vec(); drive_vec(v);
    cfg_valid = 1; cfg_ctrl = '0; cfg_seen = 0;
    #1;
    chk("rc_in_ready", VW'(in_ready), VW'(0));
    chk("rc_occ5", VW'(occupancy), VW'(5));
    n = 0;
    while (!cfg_seen && n < 60) begin
      chk("rc_cfg_ready", VW'(cfg_ready), VW'(exp_q.size() == 0));
      step();
      if (!cfg_seen) chk("rc_in_blocked", VW'(in_ready), VW'(0));
      n++;
    end
    cfg_valid = 0;
    chk("rc_handshake", VW'(cfg_seen), VW'(1));
    in_seen = 0; n = 0;
    while (!in_seen && n < 20) begin step(); n++; end
    in_valid = 0;
    drain();
    chk("rc_new_cfg", last_out, v);

    // Random traffic with random reconfiguration attempts.
    load_cfg(rand_cfg());
    drive_vec(rand_vec());
    for (int t = 0; t < 400; t++) begin
      if (!cfg_valid && $urandom_range(0, 39) == 0) begin
        cfg_valid = 1; cfg_ctrl = rand_cfg();
      end else if (cfg_valid && $urandom_range(0, 7) == 0) begin
        cfg_valid = 0;
      end
      if (!in_valid || in_seen) begin
        in_valid = ($urandom_range(0, 3) != 0);
        drive_vec(rand_vec());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (cfg_valid) chk("rnd_in_blocked", VW'(in_ready), VW'(0));
      in_seen = 0;
      step();
    end
    drain();

    // Asynchronous reset with 6 vectors in flight.
    load_cfg(rand_cfg());
    sent = 0; n = 0;
    drive_vec(rand_vec());
    while (sent < 6 && n < 40) begin
      in_valid = 1; in_seen = 0;
      step();
      if (in_seen) begin sent++; drive_vec(rand_vec()); end
      n++;
    end
    in_valid = 0;
    chk("pre_rst_occ", VW'(occupancy), VW'(6));
    #2 n_rst = 0;
    #1;
    chk("arst_out_valid", VW'(out_valid), VW'(0));
    chk("arst_cfg_loaded", VW'(cfg_loaded), VW'(0));
    chk("arst_occupancy", VW'(occupancy), VW'(0));
    exp_q.delete();
    @(posedge clk);
    #2 n_rst = 1;
    in_valid = 1;
    for (int t = 0; t < 12; t++) begin
      step();
      chk("post_rst_in_ready", VW'(in_ready), VW'(0));
      chk("post_rst_out_valid", VW'(out_valid), VW'(0));
    end
    in_valid = 0;
    one_vec("post_rst_ident", '0, ident, ident);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/benes_xbar_pipe.md
Name: benes_xbar_pipe

Overview:
- Pipelined Benes permutation datapath. It sits directly downstream of the Benes control-bit generator and consumes its flat ctrl vector.
- Holds one loaded configuration and streams SIZE-lane data vectors through 2*log2(SIZE)-1 registered 2x2-switch stages using a valid/ready handshake.
- Reconfiguration is serialized: the pipe drains, the new ctrl vector is loaded, then traffic resumes. The vector-unit shuffle path uses this block as its lane crossbar.

Parameters:
- SIZE, 32, lane count; power of two, at least 4.
- DW, 16, bits per lane.
- TAGWIDTH, $clog2(SIZE), localparam.
- STAGES, 2*TAGWIDTH-1, localparam; number of switch layers.
- BITWIDTH, STAGES*(SIZE/2), localparam; ctrl vector width.
- OCCW, $clog2(STAGES+1), localparam; occupancy counter width.

Ports:
- clk, input, 1, clock.
- n_rst, input, 1, asynchronous active-low reset.
- cfg_valid, input, 1, new control vector offered.
- cfg_ready, output, 1, control vector accepted this cycle when high together with cfg_valid.
- cfg_ctrl, input, BITWIDTH, switch bits in generator order.
- in_valid, input, 1, input vector valid.
- in_ready, output, 1, input accepted when high together with in_valid.
- in_data, input, SIZE x DW (unpacked [SIZE-1:0]), lane data.
- out_valid, output, 1, output vector valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, SIZE x DW, permuted lanes.
- cfg_loaded, output, 1, a configuration is active.
- occupancy, output, OCCW, number of vectors in flight.

Behaviour:
- Reset is n_rst, asynchronous, active-low; the clock is clk. Reset clears the ctrl register to 0, all stage valid bits to 0, occupancy to 0, out_valid to 0, cfg_loaded to 0, and the state to UNCFG. Stage data registers are not reset.
- Switch mapping, layer i (0..STAGES-1):
  - stride = 1 << min(i, STAGES-1-i).
  - For switch j (0..SIZE/2-1): pos = (j % stride) + 2*stride*(j / stride).
  - Bit cfg_ctrl[i*SIZE/2 + j] = 1 swaps lanes pos and pos+stride; 0 passes them through.
- Each layer is followed by a register. Latency is exactly STAGES cycles from in_valid&&in_ready to out_valid under no backpressure (9 for SIZE=32).
- Pipeline flow: stage k loads when it is empty or stage k+1 loads or drains. Bubbles collapse. Throughput is 1 vector/clk with out_ready held high. out_data is held stable while out_valid && !out_ready.
- in_ready = (state==RUN) && !cfg_valid && (stage0 empty || stage0 advancing).
- States:
  - UNCFG: in_ready=0, cfg_ready=1. On cfg_valid, latch cfg_ctrl, set cfg_loaded, go to RUN.
  - RUN: cfg_ready=0. cfg_valid seen -> DRAIN. In the same cycle in_ready is already 0 (combinational term above), so no new beat is accepted.
  - DRAIN: in_ready=0. cfg_ready = (occupancy==0). On cfg_valid&&cfg_ready, latch cfg_ctrl, go to RUN. If cfg_valid drops while in DRAIN, return to RUN without loading.
- occupancy: +1 on input handshake, -1 on output handshake, unchanged when both occur. It never exceeds STAGES and never underflows.
- Vectors in flight always use the ctrl that was active when they were accepted. The ctrl register changes only at occupancy 0.
- cfg_ctrl is sampled only on the cfg handshake cycle.
- Reset mid-stream drops all in-flight vectors. After reset release, no out_valid appears until a new configuration and new input arrive.

Test Plan:
- Reset, then cfg_ctrl=0 loaded, in_data lane k = k, out_ready=1 -> out_valid rises exactly 9 cycles after the input handshake (SIZE=32); out_data lane k = k.
- Only bit 0 set (layer 0, switch 0), lane k = k -> out lanes 0/1 = 1/0, others unchanged. Only bit 7*16+0 set (layer 7, stride 2, switch 0) -> lanes 0 and 2 swapped.
- Middle layer 4 (stride 16), all 16 bits set -> out lane k = (k+16)%32. A stream of 20 back-to-back vectors gives 20 consecutive out_valid cycles.
- out_ready=0 for 15 cycles mid-stream of 12 vectors -> in_ready drops once all 9 stages are full; occupancy=9; no vectors lost or duplicated; held out_data stable.
- cfg_valid asserted with 5 vectors in flight -> in_ready=0 immediately; cfg_ready=1 only once occupancy=0; the 5 old vectors use the old permutation and the next vector uses the new one.
- n_rst pulsed low with occupancy=6 -> out_valid=0, cfg_loaded=0, occupancy=0 immediately; in_ready stays 0 until cfg is reloaded.
